// File: rtl/mux_nx1_stream.sv
// ============================================================================
// mux_nx1_stream : N:1 stream mux with a registered valid/ready output stage.
// Optional round-robin arbitration when MUX_NX1_STREAM_RR_EN is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mux_nx1_stream #(
  parameter int N    = 4,
  parameter int W    = 3,
  parameter int SELW = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  input  logic [SELW-1:0] sel,
  output logic [W-1:0]    out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SELW-1:0] out_grant
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    data_q, data_d;
  logic [SELW-1:0] grant_q, grant_d;

  logic            load_en;
  logic            chosen;
  logic [SELW-1:0] chan;
  logic            accept;
  logic [W-1:0]    chan_data;

  assign load_en = (state_q == EMPTY) || out_ready;

`ifdef MUX_NX1_STREAM_RR_EN
  logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
  logic            unused_sel;

  assign unused_sel = ^sel;

  // Scan channels starting at rr_ptr, wrapping modulo N; first valid wins.
  always_comb begin
    logic [SELW:0] idx;
    idx    = '0;
    chosen = 1'b0;
    chan   = '0;
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, rr_ptr_q} + (SELW+1)'(k);
      if (idx >= (SELW+1)'(N)) begin
        idx = idx - (SELW+1)'(N);
      end
      if (!chosen && in_valid[idx[SELW-1:0]]) begin
        chosen = 1'b1;
        chan   = idx[SELW-1:0];
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (chan == SELW'(N-1)) ? '0 : chan + SELW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  assign chan   = sel;
  assign chosen = ({1'b0, sel} < (SELW+1)'(N));
`endif

  // Ready is forced low during reset so no producer sees a handshake.
  for (genvar i = 0; i < N; i++) begin : g_rdy
    assign in_ready[i] = reset_n && load_en && chosen && (chan == SELW'(i));
  end

  assign accept = |(in_ready & in_valid);

  always_comb begin
    chan_data = '0;
    for (int i = 0; i < N; i++) begin
      if (chan == SELW'(i)) begin
        chan_data = in_data[i*W +: W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    grant_d = grant_q;
    if (load_en) begin
      if (accept) begin
        state_d = FULL;
        data_d  = chan_data;
        grant_d = chan;
      end else begin
        state_d = EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      grant_q <= grant_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_grant = grant_q;

endmodule

`default_nettype wire

// File: doc/mux_nx1_stream.md
Name: mux_nx1_stream

Overview:
- Parametrised successor to the team's 2:1 bit-sliced mux: selects one of N channels of W-bit data and forwards it through a registered valid/ready output stage.
- Adds per-channel handshakes, backpressure, an out-of-range select guard, and an optional round-robin arbitration mode.
- Sits between multiple producer blocks and a single consumer in lab datapaths.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 3, data width per channel.
- SELW, 2, select/grant width; must satisfy 2**SELW >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; combinational.
- sel  input  SELW  channel select in fixed mode; ignored when RR_EN is defined.
- out_data  output  W  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  consumer ready.
- out_grant  output  SELW  registered index of the channel that produced out_data.

Behaviour:
- Reset (reset_n = 0, asynchronous): out_valid = 0, out_data = 0, out_grant = 0, rr_ptr = 0. All in_ready are 0 while in reset.
- Output stage has two states, EMPTY (out_valid = 0) and FULL (out_valid = 1).
- load_en = !out_valid || out_ready.
- Channel choice c (combinational):
  - Fixed mode: c = sel.
  - If sel >= N, no channel is chosen: all in_ready = 0 and nothing is accepted.
- in_ready[i] = load_en && (i == c); only one bit can be high in any cycle.
- Accept occurs when in_valid[c] && in_ready[c]. On the next rising edge: out_data <= in_data[c], out_grant <= c, out_valid <= 1.
- If load_en = 1 and no accept occurs, out_valid <= 0 on the next edge. out_data and out_grant hold their previous values.
- If load_en = 0 (FULL and out_ready = 0), all output registers hold. out_data must be stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle when out_ready is held at 1. Simultaneous consume and accept in the same cycle is legal and keeps the stage FULL with new data.
- sel may change on any cycle. The choice is made per beat with no locking; a beat already in the output register is unaffected by later sel changes.
- Valid channels that are not chosen are stalled (in_ready = 0). Their data is not consumed or dropped.
- Reset asserted mid-transfer: the pending beat is discarded and the stage returns to EMPTY immediately. Producers must re-present their data after reset.
- Width rules:
  - out_data is exactly W bits; no extension or truncation.
  - out_grant is zero-extended from c to SELW bits.

Optional Feature:
- Macro: MUX_NX1_STREAM_RR_EN.
- When defined, the block runs in round-robin arbitration mode:
  - sel is ignored.
  - c = the first index i with in_valid[i] = 1, searching rr_ptr, rr_ptr+1, ..., wrapping from N-1 to 0.
  - If no channel is valid, no grant is made.
  - On accept, rr_ptr <= c+1, wrapping to 0 after N-1. rr_ptr holds when there is no accept or when load_en = 0.
  - No channel waits more than N-1 accepts while its in_valid stays high.
- When not defined, the block uses fixed-select mode only and contains no rr_ptr register.

Test Plan:
- Reset check: drive reset_n = 0 with random inputs -> out_valid = 0, out_data = 0, out_grant = 0, in_ready = 4'b0000. Release reset -> first accept is visible 1 cycle later.
- Fixed select, N = 4, W = 3: sel = 2, in_data channel 2 = 3'b101, in_valid = 4'b0100, out_ready = 1 -> next cycle out_data = 3'b101, out_grant = 2, out_valid = 1. Result is identical to the 2:1 mux truth table per bit.
- Backpressure: stage FULL with 3'b011, out_ready = 0 for 3 cycles while sel and in_data change -> out_data stays 3'b011, in_ready = 0. Set out_ready = 1 -> new beat loads on the same edge the old one is consumed.
- Out-of-range select: N = 3, SELW = 2, sel = 3, all in_valid = 1 -> in_ready = 0 and out_valid falls to 0 after the current beat is consumed.
- Round robin (MUX_NX1_STREAM_RR_EN): N = 4, all in_valid held at 1, out_ready = 1 -> out_grant sequence 0, 1, 2, 3, 0. With in_valid = 4'b1010 -> 1, 3, 1, 3.
- Reset mid-stream: assert reset_n = 0 while FULL and out_ready = 0 -> out_valid drops without waiting for a clock edge. After release, rr_ptr = 0 and the first grant goes to the lowest valid channel.
